regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning number of write requesters.
REQ-002 SHALL have parameter DW, default 8, meaning register data width.
REQ-003 SHALL have parameter AW, default 3, meaning register address width (8 registers).
REQ-004 SHALL have port clkg  in  1  gated core clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port hold_i  in  1  core stall; while high, no new grant.
REQ-007 SHALL have port req_valid_i  in  NREQ  per-requester write request.
REQ-008 SHALL have port req_rd_i  in  NREQ*AW  per-requester destination address; slice k belongs to requester k.
REQ-009 SHALL have port req_dat_i  in  NREQ*DW  per-requester write data; slice k belongs to requester k.
REQ-010 SHALL have port req_ready_o  out  NREQ  one-hot grant; combinational, in the same cycle as the accepted valid.
REQ-011 SHALL have port we_o  out  1  registered register-file write enable.
REQ-012 SHALL have port rd_o  out  AW  registered register-file write address.
REQ-013 SHALL have port dat_o  out  DW  registered register-file write data.
REQ-014 SHALL have port conflict_cnt_o  out  8  saturating count of contended cycles.

Function
REQ-015 SHALL accept a transfer from requester k when req_valid_i[k] and req_ready_o[k] are both high at a clkg edge.
REQ-016 SHALL assert at most one req_ready_o bit per cycle, and SHALL assert none while hold_i=1 or no valid is high.
REQ-017 SHALL drive we_o=1, rd_o=winner address and dat_o=winner data on the cycle after acceptance (latency 1); otherwise we_o=0, and rd_o and dat_o hold their last values.
REQ-018 SHALL keep the request stable: a requester SHALL hold valid, address and data until accepted; the arbiter does not buffer unaccepted requests.
REQ-019 SHALL select the winner per REQ-028/029 among the valid requesters only.
REQ-020 SHALL increment conflict_cnt_o by 1 on each cycle with two or more valid bits high and hold_i=0, saturating at 255 with no wrap.
REQ-021 SHALL discard any request to address 0 (zero register): it SHALL be accepted normally and SHALL produce we_o=0 on the next cycle.
REQ-022 SHALL, while hold_i=1, keep arbitration state unchanged and drive we_o=0 on the next cycle; any in-flight registered write from the prior cycle still issues.

Reset
REQ-023 SHALL, while rst=1, force we_o=0, rd_o=0, dat_o=0, conflict_cnt_o=0, the round-robin pointer to 0 and req_ready_o to all zeros, independent of clkg.
REQ-024 SHALL, when rst asserts mid-operation, drop any accepted-but-unissued write (no we_o pulse after reset release).
REQ-025 SHALL grant on the first clkg edge after rst deasserts if a valid is present.

Configuration
REQ-026 SHALL use the macro RF_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-027 SHALL implement the pointer register only when RF_ARB_ROUND_ROBIN_EN is defined.
REQ-028 SHALL, with RF_ARB_ROUND_ROBIN_EN defined, grant the first valid requester at or after the pointer, wrapping from NREQ-1 to 0, and after a grant to k SHALL set the pointer to (k+1) mod NREQ.
REQ-029 SHALL, without RF_ARB_ROUND_ROBIN_EN, use fixed priority in which the lowest index wins.

Structure
REQ-030 SHALL place the NREQ, DW and AW defaults and the zero-register address constant in the shared core package.
REQ-031 SHALL contain one sub-module, rr_picker: a combinational one-hot picker taking valid and pointer inputs and producing the grant.

Verification
REQ-032 SHALL verify: only req1 valid, rd=5, dat=0xA7 -> ready[1] in the same cycle; next cycle we_o=1, rd_o=5, dat_o=0xA7.
REQ-033 SHALL verify, with RF_ARB_ROUND_ROBIN_EN: all three requesters valid for 3 cycles -> grants 0,1,2 in order, and conflict_cnt_o=3.
REQ-034 SHALL verify, without the macro: req0 and req2 valid for 2 cycles -> req0 granted both cycles and req2 starved.
REQ-035 SHALL verify: hold_i=1 with req0 valid -> no ready, we_o=0; after hold_i drops -> ready[0] in that cycle.
REQ-036 SHALL verify: req0 valid with rd=0 -> ready[0]=1, and next cycle we_o=0.
REQ-037 SHALL verify: rst pulsed mid-cycle right after an acceptance -> we_o stays 0, and conflict_cnt_o=0 after reset.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared core constants for the register-file write arbiter: parameter
// defaults, the zero-register address and the saturating counter ceiling.
package regfile_wr_arbiter_pkg;

  localparam int unsigned NREQ_DEF      = 3;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned AW_DEF        = 3;
  localparam int unsigned ZERO_REG_ADDR = 0;
  localparam logic [7:0]  CNT_MAX       = 8'hFF;

  // Pointer width; a single requester still needs a 1-bit pointer.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Combinational one-hot picker: grants the first valid bit at or after
// ptr_i, wrapping from N-1 to 0. With ptr_i tied to 0 it is fixed priority.
module rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < int'(N); i++) begin
      idx = (int'(ptr_i) + i) % int'(N);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates NREQ register-file write requesters onto one registered write port.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic             clkg,
  input  logic             rst,
  input  logic             hold_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*AW-1:0] req_rd_i,
  input  logic [NREQ*DW-1:0] req_dat_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic             we_o,
  output logic [AW-1:0]    rd_o,
  output logic [DW-1:0]    dat_o,
  output logic [7:0]       conflict_cnt_o
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] pick, grant;
  logic            accept;
  logic [AW-1:0]   win_rd;
  logic [DW-1:0]   win_dat;
  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [7:0]      cnt_q, cnt_d;

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  assign ptr = ptr_q;

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < int'(NREQ); k++)
      if (grant[k]) win_idx = PW'(k);
    ptr_d = ptr_q;
    if (accept)
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  rr_picker #(.N(NREQ), .PW(PW)) u_rr_picker (
    .valid_i (req_valid_i),
    .ptr_i   (ptr),
    .grant_o (pick)
  );

  // Handshake: a transfer from k happens at a clkg edge where req_valid_i[k]
  // and req_ready_o[k] are both high; ready is combinational and never
  // asserted under hold or reset, so requesters must hold their request.
  assign grant       = (rst || hold_i) ? '0 : pick;
  assign req_ready_o = grant;
  assign accept      = |grant;

  always_comb begin
    win_rd  = '0;
    win_dat = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant[k]) begin
        win_rd  = req_rd_i[k*AW +: AW];
        win_dat = req_dat_i[k*DW +: DW];
      end
    end
    // Writes to the zero register are accepted but never issued.
    we_d  = accept && (win_rd != AW'(ZERO_REG_ADDR));
    rd_d  = we_d ? win_rd  : rd_q;
    dat_d = we_d ? win_dat : dat_q;
    cnt_d = cnt_q;
    if (!hold_i && ($countones(req_valid_i) > 1) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      rd_q  <= '0;
      dat_q <= '0;
      cnt_q <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
      ptr_q <= '0;
`endif
    end else begin
      we_q  <= we_d;
      rd_q  <= rd_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
`ifdef RF_ARB_ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign we_o           = we_q;
  assign rd_o           = rd_q;
  assign dat_o          = dat_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; covers the policy selected by
// RF_ARB_ROUND_ROBIN_EN at compile time.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic              clkg;
  logic              rst;
  logic              hold_i;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*AW-1:0] req_rd_i;
  logic [NREQ*DW-1:0] req_dat_i;
  logic [NREQ-1:0]    req_ready_o;
  logic              we_o;
  logic [AW-1:0]     rd_o;
  logic [DW-1:0]     dat_o;
  logic [7:0]        conflict_cnt_o;

  int total_cnt = 0;
  int bad_cnt   = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clkg           (clkg),
    .rst            (rst),
    .hold_i         (hold_i),
    .req_valid_i    (req_valid_i),
    .req_rd_i       (req_rd_i),
    .req_dat_i      (req_dat_i),
    .req_ready_o    (req_ready_o),
    .we_o           (we_o),
    .rd_o           (rd_o),
    .dat_o          (dat_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  // clock / reset
  initial clkg = 1'b0;
  always #5 clkg = ~clkg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int k, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] dat);
    req_valid_i[k]        = v;
    req_rd_i[k*AW +: AW]  = rd;
    req_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic clear_reqs();
    req_valid_i = '0;
    req_rd_i    = '0;
    req_dat_i   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clkg);
    rst    = 1'b1;
    hold_i = 1'b0;
    clear_reqs();
    @(negedge clkg);
    @(negedge clkg);
    rst = 1'b0;
  endtask

  // one clock: advance to the edge and sample just after it
  task automatic tick();
    @(posedge clkg);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    hold_i = 1'b0;
    clear_reqs();
    set_req(1, 1'b1, 3'd5, 8'hA7);
    #12;
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_we",    32'(we_o), 32'h0);
    check("rst_rd",    32'(rd_o), 32'h0);
    check("rst_dat",   32'(dat_o), 32'h0);
    check("rst_cnt",   32'(conflict_cnt_o), 32'h0);

    // single requester, released straight out of reset
    @(negedge clkg);
    rst = 1'b0;
    #1;
    check("single_ready", 32'(req_ready_o), 32'b010);
    tick();
    check("single_we",  32'(we_o), 32'h1);
    check("single_rd",  32'(rd_o), 32'h5);
    check("single_dat", 32'(dat_o), 32'hA7);
    @(negedge clkg);
    clear_reqs();
    #1;
    check("idle_ready", 32'(req_ready_o), 32'h0);
    tick();
    check("idle_we",      32'(we_o), 32'h0);
    check("idle_rd_hold", 32'(rd_o), 32'h5);
    check("idle_dat_hold", 32'(dat_o), 32'hA7);

`ifdef RF_ARB_ROUND_ROBIN_EN
    apply_reset();
    set_req(0, 1'b1, 3'd1, 8'h11);
    set_req(1, 1'b1, 3'd2, 8'h22);
    set_req(2, 1'b1, 3'd3, 8'h33);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rr_ready", 32'(req_ready_o), 32'(1 << c));
      tick();
      check("rr_we",  32'(we_o), 32'h1);
      check("rr_rd",  32'(rd_o), 32'(c + 1));
      check("rr_dat", 32'(dat_o), 32'(8'h11 * (c + 1)));
      @(negedge clkg);
    end
    clear_reqs();
    #1;
    check("rr_cnt", 32'(conflict_cnt_o), 32'd3);
`else
    apply_reset();
    set_req(0, 1'b1, 3'd6, 8'h60);
    set_req(2, 1'b1, 3'd7, 8'h70);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("fp_ready", 32'(req_ready_o), 32'b001);
      tick();
      check("fp_rd",  32'(rd_o), 32'h6);
      check("fp_dat", 32'(dat_o), 32'h60);
      @(negedge clkg);
    end
    clear_reqs();
    #1;
    check("fp_cnt", 32'(conflict_cnt_o), 32'd2);
`endif

    // hold blocks grants and conflict counting
    apply_reset();
    hold_i = 1'b1;
    set_req(0, 1'b1, 3'd4, 8'h44);
    set_req(1, 1'b1, 3'd2, 8'h22);
    #1;
    check("hold_ready", 32'(req_ready_o), 32'h0);
    tick();
    check("hold_we",  32'(we_o), 32'h0);
    check("hold_cnt", 32'(conflict_cnt_o), 32'h0);
    @(negedge clkg);
    set_req(1, 1'b0, 3'd0, 8'h00);
    hold_i = 1'b0;
    #1;
    check("unhold_ready", 32'(req_ready_o), 32'b001);
    tick();
    check("unhold_we", 32'(we_o), 32'h1);
    check("unhold_rd", 32'(rd_o), 32'h4);
    @(negedge clkg);
    hold_i = 1'b1;
    #1;
    check("inflight_we",    32'(we_o), 32'h1);
    check("hold2_ready",    32'(req_ready_o), 32'h0);
    tick();
    check("hold2_we", 32'(we_o), 32'h0);

    // zero-register write is accepted and dropped
    apply_reset();
    set_req(0, 1'b1, 3'd0, 8'h5A);
    #1;
    check("zero_ready", 32'(req_ready_o), 32'b001);
    tick();
    check("zero_we",  32'(we_o), 32'h0);
    check("zero_dat", 32'(dat_o), 32'h0);

    // reset right after an acceptance
    apply_reset();
    set_req(1, 1'b1, 3'd6, 8'hC3);
    set_req(2, 1'b1, 3'd5, 8'hB2);
    #1;
    check("pre_rst_ready", 32'(req_ready_o), 32'b010);
    tick();
    check("pre_rst_we",  32'(we_o), 32'h1);
    check("pre_rst_cnt", 32'(conflict_cnt_o), 32'h1);
    rst = 1'b1;
    #2;
    check("mid_rst_we",  32'(we_o), 32'h0);
    clear_reqs();
    rst = 1'b0;
    #1;
    check("post_rst_we", 32'(we_o), 32'h0);
    tick();
    check("post_rst_we2", 32'(we_o), 32'h0);
    check("post_rst_cnt", 32'(conflict_cnt_o), 32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
